arcade_ce_gen: RTL
==================

// Module: arcade_ce_gen
// PURPOSE
//   Multi-channel fractional clock-enable generator. Replaces ad-hoc divide-by-N counters
//   (CPU enable, sound clock, pixel enable) in arcade top levels.
//   Each channel emits NUM enables per DEN clk_sys cycles via phase accumulator, plus a toggle (square) output.
//   Adds per-channel runtime ratio, global pause and phase resync, which fixed counters lack.
// PARAMETERS
//   NUM_CH   3    number of independent channels
//   ACC_W    16   width of NUM, DEN and accumulator per channel
// PORTS
//   clk_sys   in   1               system clock; all logic on rising edge
//   reset     in   1               synchronous, active-high
//   cfg_num   in   NUM_CH*ACC_W    packed numerators, ch i = [i*ACC_W +: ACC_W]
//   cfg_den   in   NUM_CH*ACC_W    packed denominators, same packing
//   cfg_load  in   NUM_CH          per-channel strobe: latch num/den, clear that channel's phase
//   pause     in   1               freeze all channels (ce low, acc/sq held)
//   resync    in   1               clear all accumulators and sq in the same cycle (phase align)
//   ce        out  NUM_CH          registered one-cycle enable pulses
//   sq        out  NUM_CH          registered square output, toggles on every ce
//   active    out  NUM_CH          1 = channel has a non-zero ratio latched
// BEHAVIOUR
//   Reset (cycle reset=1): num_r/den_r <= cfg_num/cfg_den; acc <= 0; ce <= 0; sq <= 0.
//   active <= 1 for each channel whose sampled cfg_num != 0 and cfg_den != 0.
//   Per channel, each clock when not reset, not paused, not resync, no load:
//     sum = acc + num_eff, computed ACC_W+1 bits wide (no overflow).
//     num_eff = min(num_r, den_r).
//     sum >= den_r: acc <= sum - den_r; ce <= 1; sq <= ~sq.
//     Otherwise: acc <= sum; ce <= 0.
//   Result: exactly num_eff pulses per den_r cycles, evenly spread; acc < den_r always.
//   Latency: ce rises in the clock after the edge where sum reaches den_r.
//     1/10 from reset: acc counts 1..9; ce high on the 10th clock after reset falls, then every 10th.
//   num_r >= den_r: ce held high every clock, sq toggles every clock.
//   num_r = 0 or den_r = 0: channel idle: ce=0, acc=0, sq held, active=0.
//   cfg_load[i]: num_r/den_r latched from inputs; acc=0; ce=0; active updated; sq kept.
//     The new ratio applies from the next clock.
//   pause=1: ce forced 0 next clock; acc and sq held; cfg_load still honoured.
//     On pause release, counting resumes from the held acc (no lost phase).
//   resync=1: all acc <= 0, sq <= 0, ce <= 0. Both resync and cfg_load[i] apply in the same cycle.
//   Priority: reset > resync > cfg_load > pause > count.
//   Idle ratio with pause: ce=0 regardless.
//   Outputs are pure registers; no combinational path from any input to ce/sq/active.
// TESTING
//   1. num=1, den=10, run 100 clocks -> ce high exactly 10 times, spacing 10, first 10 clocks after reset.
//   2. num=3, den=10 -> 3 pulses per 10 clocks, spacing pattern 4,3,3 repeating; never two adjacent.
//   3. num=1, den=34 on ch1 -> sq period 68 clocks, 50% duty (matches legacy sound divider).
//   4. Pause 7 clocks mid-run at num=1, den=10 -> no ce during pause.
//      Next ce arrives (remaining phase) clocks after release, where remaining phase = 10 - count before pause.
//   5. cfg_load num=2, den=5 at clock 23 -> acc cleared; pulses at +3,+5 relative then every 5 (2 per 5).
//   6. num=12, den=5 -> ce constant 1; den=0 -> ce=0, active=0.
//      resync together with cfg_load -> all sq=0 next clock.

Source files
------------

// File: rtl/arcade_ce_gen.sv
// ---------------------------------------------------------------------------
// arcade_ce_gen
//   Multi-channel fractional clock-enable generator. Each channel emits
//   num_eff = min(num, den) single-cycle enable pulses per den clk_sys cycles,
//   spread evenly by a phase accumulator, plus a square output that toggles
//   on every pulse. Ratios can be reloaded at runtime per channel; all
//   channels can be frozen (pause) or phase-aligned (resync) together.
//
// Ports
//   clk_sys   in   system clock, all logic on the rising edge
//   reset     in   synchronous, active-high; also latches cfg_num/cfg_den
//   cfg_num   in   packed numerators,   ch i = [i*ACC_W +: ACC_W]
//   cfg_den   in   packed denominators, same packing
//   cfg_load  in   per-channel strobe: latch ratio, clear phase, keep sq
//   pause     in   freeze all channels (ce low, acc/sq held)
//   resync    in   clear every accumulator and sq in the same cycle
//   ce        out  registered one-cycle enable pulses
//   sq        out  registered square output, toggles on each ce
//   active    out  channel holds a non-zero num and den
//
// Priority per channel: reset > resync > cfg_load > pause > count.
// resync and cfg_load[i] in the same cycle both take effect.
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module arcade_ce_gen #(
  parameter int NUM_CH = 3,
  parameter int ACC_W  = 16
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic [NUM_CH*ACC_W-1:0] cfg_num,
  input  logic [NUM_CH*ACC_W-1:0] cfg_den,
  input  logic [NUM_CH-1:0]       cfg_load,
  input  logic                    pause,
  input  logic                    resync,
  output logic [NUM_CH-1:0]       ce,
  output logic [NUM_CH-1:0]       sq,
  output logic [NUM_CH-1:0]       active
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [ACC_W-1:0] num_r;
    logic [ACC_W-1:0] den_r;
    logic [ACC_W-1:0] acc;
    logic             ce_r;
    logic             sq_r;
    logic             active_r;

    logic [ACC_W-1:0] new_num;
    logic [ACC_W-1:0] new_den;
    logic             new_active;
    logic [ACC_W-1:0] num_eff;
    logic [ACC_W:0]   sum;
    logic [ACC_W:0]   rem;
    logic             wrap;
    logic             idle;

    assign new_num    = cfg_num[i*ACC_W +: ACC_W];
    assign new_den    = cfg_den[i*ACC_W +: ACC_W];
    assign new_active = (new_num != '0) && (new_den != '0);

    // Clamping num to den makes num >= den degenerate to "pulse every clock"
    // while keeping acc < den_r, so the subtraction below never underflows.
    assign num_eff = (num_r < den_r) ? num_r : den_r;
    // One extra bit so acc + num_eff cannot wrap before the compare.
    assign sum  = {1'b0, acc} + {1'b0, num_eff};
    assign rem  = sum - {1'b0, den_r};
    assign wrap = (sum >= {1'b0, den_r});
    assign idle = (num_r == '0) || (den_r == '0);

    always_ff @(posedge clk_sys) begin
      if (reset) begin
        num_r    <= new_num;
        den_r    <= new_den;
        active_r <= new_active;
        acc      <= '0;
        ce_r     <= 1'b0;
        sq_r     <= 1'b0;
      end else if (resync) begin
        // Phase-align every channel; a coincident load still lands.
        acc  <= '0;
        ce_r <= 1'b0;
        sq_r <= 1'b0;
        if (cfg_load[i]) begin
          num_r    <= new_num;
          den_r    <= new_den;
          active_r <= new_active;
        end
      end else if (cfg_load[i]) begin
        // New ratio starts from a clean phase; sq keeps its level.
        num_r    <= new_num;
        den_r    <= new_den;
        active_r <= new_active;
        acc      <= '0;
        ce_r     <= 1'b0;
      end else if (pause) begin
        // Hold acc and sq so counting resumes without losing phase.
        ce_r <= 1'b0;
      end else if (idle) begin
        acc  <= '0;
        ce_r <= 1'b0;
      end else if (wrap) begin
        acc  <= rem[ACC_W-1:0];
        ce_r <= 1'b1;
        sq_r <= ~sq_r;
      end else begin
        acc  <= sum[ACC_W-1:0];
        ce_r <= 1'b0;
      end
    end

    assign ce[i]     = ce_r;
    assign sq[i]     = sq_r;
    assign active[i] = active_r;
  end

endmodule
